// File: rtl/mem_access_ctrl_if.sv
// Bundles the CPU-side request/ack signals and the memory port of the
// unified instruction/data memory access controller.
// The master view is the controller. The slave view is the CPU control
// path together with the memory model.
interface mem_access_ctrl_if;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        fetchAck;
    logic [31:0] instrOut;

    logic        dataReq;
    logic        dataWe;
    logic [31:0] dataAddr;
    logic [31:0] dataWData;
    logic        dataAck;
    logic [31:0] dataRData;

    logic        errOut;
    logic        busy;

    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteEnable;
    logic [31:0] memData;

    modport master (
        input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memData,
        output fetchAck, instrOut, dataAck, dataRData, errOut, busy,
               memAddress, memWriteData, memWriteEnable
    );

    modport slave (
        output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memData,
        input  fetchAck, instrOut, dataAck, dataRData, errOut, busy,
               memAddress, memWriteData, memWriteEnable
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator side of the unified instruction/data memory port.
// Arbitrates fetch against load/store, where data has fixed priority.
// Holds the address for WAIT_CYCLES extra cycles before the commit/capture
// edge, then returns a one-cycle ack.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no access in flight; a pending request is accepted at the edge
//   ST_ACCESS | address/data held on the port; counter counts wait states,
//             | and counter==0 is the commit/capture cycle
//   ST_RESP   | one-cycle ack (and error flag) to the requester
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 513
) (
    input  logic              Clk,
    input  logic              Rst_n,
    mem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic        w_accept;
    logic        w_commit;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_src_data;
    logic        r_oor;
    logic [31:0] r_instr;
    logic [31:0] r_rdata;

    logic [31:0] w_req_addr;
    logic        w_req_oor;

    // The winning request's address is range-checked once, at accept time.
    // This keeps the commit-cycle decode down to a few flops.
    assign w_req_addr = bus.dataReq ? bus.dataAddr : bus.fetchAddr;
    assign w_req_oor  = (w_req_addr >= LP_DEPTH);

    assign w_commit = (r_state == ST_ACCESS) && (r_count == 4'd0);

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.dataReq || bus.fetchReq) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_count_nxt = LP_WAIT;
                end
            end
            ST_ACCESS: begin
                if (r_count != 4'd0) begin
                    w_count_nxt = r_count - 4'd1;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Operands are latched only at accept. Changes on the request side while
    // busy are ignored. A fetch leaves the last store data on the port.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_src_data <= 1'b0;
            r_oor      <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= w_req_addr;
            r_oor      <= w_req_oor;
            r_src_data <= bus.dataReq;
            r_we       <= bus.dataReq & bus.dataWe;
            if (bus.dataReq) begin
                r_wdata <= bus.dataWData;
            end
        end
    end

    // Read data is captured at the commit edge. An out-of-range read returns
    // zero rather than whatever the memory drives.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_instr <= 32'd0;
            r_rdata <= 32'd0;
        end else if (w_commit && !r_we) begin
            if (r_src_data) begin
                r_rdata <= r_oor ? 32'd0 : bus.memData;
            end else begin
                r_instr <= r_oor ? 32'd0 : bus.memData;
            end
        end
    end

    // All strobes are decoded from registers only, so they are glitch-free.
    // They also fall as soon as reset clears the state register.
    assign bus.memAddress     = r_addr;
    assign bus.memWriteData   = r_wdata;
    assign bus.memWriteEnable = w_commit & r_we & ~r_oor;
    assign bus.fetchAck       = (r_state == ST_RESP) & ~r_src_data;
    assign bus.dataAck        = (r_state == ST_RESP) &  r_src_data;
    assign bus.errOut         = (r_state == ST_RESP) &  r_oor;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.instrOut       = r_instr;
    assign bus.dataRData      = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. The main instance uses WAIT_CYCLES=1 and a
// read/write memory model. A second instance uses WAIT_CYCLES=0 and covers
// back-to-back fetches.
module tb_mem_access_ctrl;
    localparam int W1    = 1;
    localparam int W0    = 0;
    localparam int DEPTH = 513;

    logic Clk;
    logic Rst_n;
    int   total = 0;
    int   bad   = 0;

    mem_access_ctrl_if bus1 ();
    mem_access_ctrl_if bus0 ();

    mem_access_ctrl #(.WAIT_CYCLES(W1), .MEM_DEPTH(DEPTH)) u_dut1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(W0), .MEM_DEPTH(DEPTH)) u_dut0 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model. An unwritten location reads a fixed initial pattern.
    logic [31:0] mem     [DEPTH];
    bit          mem_vld [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    function automatic logic [31:0] init_val(input int a);
        case (a)
            1:       return 32'h00000001;
            128:     return 32'h8c030000;
            132:     return 32'h00430820;
            136:     return 32'h8c050002;
            140:     return 32'h8c010002;
            144:     return 32'h10600004;
            default: return (32'(a) * 32'h01000193) ^ 32'h5a5a0000;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a >= 32'(DEPTH)) return 32'hdeadbeef;
        return mem_vld[a[9:0]] ? mem[a[9:0]] : init_val(int'(a));
    endfunction

    assign bus1.memData = mem_rd(bus1.memAddress);
    assign bus0.memData = mem_rd(bus0.memAddress);

    always @(posedge Clk) begin
        if (bus1.memWriteEnable && bus1.memAddress < 32'(DEPTH)) begin
            mem[bus1.memAddress[9:0]]     <= bus1.memWriteData;
            mem_vld[bus1.memAddress[9:0]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=1 instance. The expectations come from
    // the reference model: ack after W1+2 cycles, out-of-range reads give 0,
    // and only in-range stores strobe the memory.
    task automatic run_txn(input bit is_data, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          ack_at;
        int          mwe_n;
        logic [31:0] mwe_addr;
        logic [31:0] mwe_data;
        logic [31:0] obs_rd;
        logic        obs_err;
        logic        obs_other;
        exp_err  = (addr >= 32'(DEPTH));
        exp_rd   = exp_err ? 32'd0 : ref_mem[addr[9:0]];
        ack_at   = -1;
        mwe_n    = 0;
        mwe_addr = 32'd0;
        mwe_data = 32'd0;
        obs_rd   = 32'd0;
        obs_err  = 1'b0;
        obs_other = 1'b0;
        @(negedge Clk);
        if (is_data) begin
            bus1.dataReq = 1'b1; bus1.dataWe = we; bus1.dataAddr = addr; bus1.dataWData = wdata;
        end else begin
            bus1.fetchReq = 1'b1; bus1.fetchAddr = addr;
        end
        for (int k = 1; k <= 40 && ack_at < 0; k++) begin
            @(negedge Clk);
            if (bus1.memWriteEnable) begin
                mwe_n++;
                mwe_addr = bus1.memAddress;
                mwe_data = bus1.memWriteData;
            end
            if (is_data ? bus1.dataAck : bus1.fetchAck) begin
                ack_at    = k;
                obs_rd    = is_data ? bus1.dataRData : bus1.instrOut;
                obs_err   = bus1.errOut;
                obs_other = is_data ? bus1.fetchAck : bus1.dataAck;
                bus1.dataReq  = 1'b0;
                bus1.fetchReq = 1'b0;
            end
        end
        bus1.dataReq  = 1'b0;
        bus1.fetchReq = 1'b0;
        check({tag, "_latency"}, 32'(ack_at), 32'(W1 + 2));
        check({tag, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
        check({tag, "_other_ack"}, {31'd0, obs_other}, 32'd0);
        check({tag, "_we_pulses"}, 32'(mwe_n), (is_data && we && !exp_err) ? 32'd1 : 32'd0);
        if (is_data && we) begin
            if (!exp_err) begin
                check({tag, "_we_addr"}, mwe_addr, addr);
                check({tag, "_we_data"}, mwe_data, wdata);
                ref_mem[addr[9:0]] = wdata;
            end
        end else begin
            check({tag, "_rdata"}, obs_rd, exp_rd);
        end
    endtask

    initial begin
        int data_at;
        int fetch_at;
        int idle_gap;
        int a0;
        int a1;
        logic [31:0] ra;
        logic [31:0] saved;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        bus1.fetchReq = 0; bus1.fetchAddr = 0; bus1.dataReq = 0; bus1.dataWe = 0;
        bus1.dataAddr = 0; bus1.dataWData = 0;
        bus0.fetchReq = 0; bus0.fetchAddr = 0; bus0.dataReq = 0; bus0.dataWe = 0;
        bus0.dataAddr = 0; bus0.dataWData = 0;

        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {31'd0, bus1.busy}, 32'd0);
        check("rst_mwe", {31'd0, bus1.memWriteEnable}, 32'd0);
        check("rst_addr", bus1.memAddress, 32'd0);
        check("rst_acks", {30'd0, bus1.fetchAck, bus1.dataAck}, 32'd0);
        check("rst_instr", bus1.instrOut, 32'd0);
        check("rst_rdata", bus1.dataRData, 32'd0);
        Rst_n = 1'b1;

        // Directed items.
        run_txn(1'b0, 1'b0, 32'd128, 32'd0, "fetch128");
        run_txn(1'b1, 1'b1, 32'd6, 32'h00000015, "store6");
        run_txn(1'b1, 1'b0, 32'd6, 32'd0, "load6");
        run_txn(1'b1, 1'b1, 32'd600, 32'h12345678, "store600");
        run_txn(1'b1, 1'b0, 32'd600, 32'd0, "load600");
        run_txn(1'b1, 1'b1, 32'd512, 32'hcafef00d, "store512");
        run_txn(1'b1, 1'b1, 32'd513, 32'h0badf00d, "store513");
        run_txn(1'b1, 1'b0, 32'd512, 32'd0, "load512");

        // Simultaneous requests: the data load wins, and the fetch follows
        // after exactly one IDLE cycle.
        @(negedge Clk);
        bus1.dataReq = 1'b1; bus1.dataWe = 1'b0; bus1.dataAddr = 32'd1;
        bus1.fetchReq = 1'b1; bus1.fetchAddr = 32'd132;
        data_at = -1; fetch_at = -1; idle_gap = 0;
        for (int k = 1; k <= 40 && fetch_at < 0; k++) begin
            @(negedge Clk);
            if (data_at >= 0 && !bus1.busy) idle_gap++;
            if (bus1.dataAck) begin
                data_at = k;
                check("arb_rdata", bus1.dataRData, ref_mem[1]);
                check("arb_fetch_not_first", {31'd0, bus1.fetchAck}, 32'd0);
                bus1.dataReq = 1'b0;
            end
            if (bus1.fetchAck) begin
                fetch_at = k;
                check("arb_instr", bus1.instrOut, ref_mem[132]);
                bus1.fetchReq = 1'b0;
            end
        end
        bus1.dataReq = 1'b0; bus1.fetchReq = 1'b0;
        check("arb_data_lat", 32'(data_at), 32'(W1 + 2));
        check("arb_fetch_lat", 32'(fetch_at), 32'(2 * W1 + 5));
        check("arb_idle_gap", 32'(idle_gap), 32'd1);

        // Random traffic against the reference model, biased toward a small
        // address window and the upper range boundary.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom_range(0, 15));
                1:       ra = 32'($urandom_range(505, 520));
                2:       ra = 32'($urandom_range(0, 1023));
                default: ra = $urandom_range(0, 1) ? 32'd512 : 32'd513;
            endcase
            case ($urandom_range(0, 2))
                0:       run_txn(1'b0, 1'b0, ra, 32'd0, "rnd_fetch");
                1:       run_txn(1'b1, 1'b0, ra, 32'd0, "rnd_load");
                default: run_txn(1'b1, 1'b1, ra, $urandom, "rnd_store");
            endcase
        end

        // Reset during the wait state of a store aborts it silently.
        saved = ref_mem[20];
        @(negedge Clk);
        bus1.dataReq = 1'b1; bus1.dataWe = 1'b1; bus1.dataAddr = 32'd20; bus1.dataWData = 32'hfeedface;
        @(negedge Clk);
        check("mid_busy", {31'd0, bus1.busy}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("mid_mwe", {31'd0, bus1.memWriteEnable}, 32'd0);
        check("mid_busy_clr", {31'd0, bus1.busy}, 32'd0);
        check("mid_addr", bus1.memAddress, 32'd0);
        check("mid_wdata", bus1.memWriteData, 32'd0);
        check("mid_outs", {bus1.instrOut | bus1.dataRData}, 32'd0);
        check("mid_flags", {29'd0, bus1.fetchAck, bus1.dataAck, bus1.errOut}, 32'd0);
        bus1.dataReq = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            check("mid_flags_hold", {29'd0, bus1.fetchAck, bus1.dataAck, bus1.memWriteEnable}, 32'd0);
        end
        Rst_n = 1'b1;
        check("mid_mem_untouched", mem_rd(32'd20), saved);
        run_txn(1'b0, 1'b0, 32'd136, 32'd0, "post_rst_fetch136");

        // WAIT_CYCLES=0 instance: fetchReq stays high, so the acks are 3 cycles apart.
        @(negedge Clk);
        bus0.fetchReq = 1'b1; bus0.fetchAddr = 32'd140;
        a0 = -1; a1 = -1;
        for (int k = 1; k <= 30 && a1 < 0; k++) begin
            @(negedge Clk);
            if (bus0.fetchAck) begin
                if (a0 < 0) begin
                    a0 = k;
                    check("w0_instr140", bus0.instrOut, 32'h8c010002);
                    bus0.fetchAddr = 32'd144;
                end else begin
                    a1 = k;
                    check("w0_instr144", bus0.instrOut, 32'h10600004);
                    bus0.fetchReq = 1'b0;
                end
            end
        end
        bus0.fetchReq = 1'b0;
        check("w0_first_lat", 32'(a0), 32'(W0 + 2));
        check("w0_spacing", 32'(a1 - a0), 32'(W0 + 3));

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
